// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, funct3 decode
// positions, FSM state encoding and byte-lane geometry.
package lsu_pkg;

  localparam int DWORD_W   = 64;
  localparam int BYTE_W    = 8;
  localparam int LANE_BITS = 3;

  // funct3[1:0] selects the access size and funct3[2] selects zero extension.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
  localparam int         F3_UNSIGNED_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_t;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [LANE_BITS-1:0] size_offset_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_offset_mask = 3'b000;
      SIZE_H:  size_offset_mask = 3'b001;
      SIZE_W:  size_offset_mask = 3'b011;
      default: size_offset_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 64-bit memory doubleword and the register
// file: extracts and extends load data, and merges partial store data into
// a previously read doubleword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DWORD_W-1:0]   read_word,
  input  logic [DWORD_W-1:0]   old_word,
  input  logic [DWORD_W-1:0]   store_data,
  input  logic [LANE_BITS-1:0] offset,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  output logic [DWORD_W-1:0]   load_result,
  output logic [DWORD_W-1:0]   merged_word
);

  logic [5:0]         bit_shift;
  logic [DWORD_W-1:0] shifted;
  logic [DWORD_W-1:0] size_mask;
  logic [DWORD_W-1:0] lane_mask;

  assign bit_shift = {offset, 3'b000};

  // Shift the addressed lane down to bit 0 and extend it to a full register.
  always_comb begin
    shifted     = read_word >> bit_shift;
    load_result = shifted;
    case (size)
      SIZE_B: load_result = is_unsigned ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
      SIZE_H: load_result = is_unsigned ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W: load_result = is_unsigned ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

  // Replace only the addressed bytes of the old doubleword with store data.
  always_comb begin
    size_mask = '1;
    case (size)
      SIZE_B:  size_mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  size_mask = 64'h0000_0000_0000_FFFF;
      SIZE_W:  size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
    lane_mask   = size_mask << bit_shift;
    merged_word = (old_word & ~lane_mask) | ((store_data << bit_shift) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit between EX/MEM and a byte-addressed 64-bit data
// memory. Every access is turned into an aligned doubleword access;
// sub-doubleword stores go through a read-modify-write sequence.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses skip memory
// and complete with resp_misalign set. Without it, the low address bits
// below the access size are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_we,
  input  logic            req_re,
  input  logic [2:0]      req_funct3,
  input  logic [RD_W-1:0] req_rd,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_misalign,
  output logic            busy
);

  lsu_state_t state, next_state;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rmw_q;
  logic [XLEN-1:0] resp_data_q;
  logic [2:0]      funct3_q;
  logic [RD_W-1:0] rd_q;
  logic            misalign_q;

  logic            accept;
  logic            trap_hit;
  logic [XLEN-1:0] aligned_addr;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] merged_word;

  assign accept = req_valid & req_ready;

  // Low bits below the access size are dropped so the lane offset is always aligned.
  assign aligned_addr = {req_addr[XLEN-1:3],
                         req_addr[2:0] & ~size_offset_mask(req_funct3[1:0])};

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = (req_we | req_re) &
                    ((req_addr[2:0] & size_offset_mask(req_funct3[1:0])) != 3'b000);
`else
  assign trap_hit = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .read_word   (mem_read_data),
    .old_word    (rmw_q),
    .store_data  (wdata_q),
    .offset      (addr_q[2:0]),
    .size        (funct3_q[1:0]),
    .is_unsigned (funct3_q[F3_UNSIGNED_BIT]),
    .load_result (load_result),
    .merged_word (merged_word)
  );

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Sequencing: one request per IDLE visit, every request ends in a single RESP cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (trap_hit)                             next_state = ST_RESP;
          else if (req_we && req_funct3[1:0] == SIZE_D) next_state = ST_STORE;
          else if (req_we)                          next_state = ST_RMW_RD;
          else if (req_re)                          next_state = ST_LOAD;
          else                                      next_state = ST_RESP;
        end
      end
      ST_LOAD:   next_state = ST_RESP;
      ST_STORE:  next_state = ST_RESP;
      ST_RMW_RD: next_state = ST_RMW_WR;
      ST_RMW_WR: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Memory strobes and handshake outputs decoded from the current state.
  always_comb begin
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    case (state)
      ST_IDLE:   req_ready = 1'b1;
      ST_LOAD:   mem_read  = 1'b1;
      ST_RMW_RD: mem_read  = 1'b1;
      ST_STORE: begin
        mem_write      = 1'b1;
        mem_write_data = wdata_q;
      end
      ST_RMW_WR: begin
        mem_write      = 1'b1;
        mem_write_data = merged_word;
      end
      ST_RESP:   resp_valid = 1'b1;
      default:   req_ready  = 1'b0;
    endcase
  end

  // Request capture at accept, load result capture in LOAD, old doubleword capture in RMW_RD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rmw_q       <= '0;
      resp_data_q <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      misalign_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= aligned_addr;
        wdata_q     <= req_wdata;
        funct3_q    <= req_funct3;
        rd_q        <= req_rd;
        misalign_q  <= trap_hit;
        resp_data_q <= '0;
      end
      if (state == ST_LOAD)   resp_data_q <= load_result;
      if (state == ST_RMW_RD) rmw_q       <= mem_read_data;
    end
  end

  assign mem_address   = {addr_q[XLEN-1:3], 3'b000};
  assign resp_data     = resp_data_q;
  assign resp_rd       = rd_q;
  assign resp_misalign = misalign_q;
  assign busy          = ~req_ready;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 16-doubleword memory around the
// DUT, and a byte-array reference model that predicts load results, memory
// contents and completion latency for directed and random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_we;
  logic        req_re;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_misalign;
  logic        busy;

  int compared = 0;
  int failed   = 0;

  logic [63:0] mem [0:15];
  logic        tb_wr = 1'b0;
  logic [3:0]  tb_idx = '0;
  logic [63:0] tb_data = '0;
  logic [7:0]  ref_mem [0:127];

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_re(req_re),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_misalign(resp_misalign),
    .busy(busy)
  );

  // Data memory: combinational read, doubleword write on posedge.
  assign mem_read_data = mem[mem_address[6:3]];
  always @(posedge clk) begin
    if (tb_wr)          mem[tb_idx] <= tb_data;
    else if (mem_write) mem[mem_address[6:3]] <= mem_write_data;
  end

  // Strobe activity counters, sampled away from the clock edge.
  always @(negedge clk) begin
    if (mem_read)              rd_cnt   <= rd_cnt + 1;
    if (mem_write)             wr_cnt   <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] refDword(input int idx);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[idx*8 + i];
    return v;
  endfunction

  task automatic setDword(input int idx, input logic [63:0] v);
    @(negedge clk);
    tb_wr = 1'b1; tb_idx = idx[3:0]; tb_data = v;
    for (int i = 0; i < 8; i++) ref_mem[idx*8 + i] = v[8*i +: 8];
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  // Present one request once the DUT is ready, then count edges from accept to resp_valid.
  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [4:0] rd, output int lat);
    @(negedge clk);
    for (int i = 0; i < 6 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_re = re; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reference behaviour from the architectural rules, then compare the response.
  task automatic doOp(input string tag, input logic we, input logic re,
                      input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wdata);
    int          size;
    int          base;
    bit          trap;
    int          exp_lat;
    logic [63:0] exp_data;
    logic [4:0]  rd;
    int          lat;
    size     = 1 << f3[1:0];
    base     = int'(addr) - (int'(addr) % size);
    trap     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap     = (we || re) && (int'(addr) % size != 0);
`endif
    exp_data = '0;
    rd       = 5'($urandom);
    if (trap) begin
      exp_lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
      exp_lat = (size == 8) ? 2 : 3;
    end else if (re) begin
      for (int i = 0; i < size; i++) exp_data[8*i +: 8] = ref_mem[base + i];
      if (!f3[2] && size < 8 && exp_data[8*size-1])
        exp_data = exp_data | ~((64'd1 << (8*size)) - 64'd1);
      exp_lat = 2;
    end else begin
      exp_lat = 1;
    end
    applyStimulus(we, re, f3, addr, wdata, rd, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_data"}, resp_data, exp_data);
    checkOutput({tag, "_rd"}, 64'(resp_rd), 64'(rd));
    checkOutput({tag, "_misalign"}, 64'(resp_misalign), 64'(trap));
    if (we) checkOutput({tag, "_memdw"}, mem[base / 8], refDword(base / 8));
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse_end"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int rd0;
    int wr0;
    logic [63:0] sh_data;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    checkOutput("rst_resp_data", resp_data, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) setDword(i, {$urandom, $urandom});
    setDword(0, 64'h0000_0000_0000_000B);
    setDword(1, 64'h0000_0000_0000_0080);
    setDword(2, 64'h1122_3344_5566_7788);

    $display("[TB] directed accesses");
    doOp("ld0", 1'b0, 1'b1, 3'd3, 64'd0, 64'd0);
    doOp("lb8", 1'b0, 1'b1, 3'd0, 64'd8, 64'd0);
    doOp("lbu8", 1'b0, 1'b1, 3'd4, 64'd8, 64'd0);
    doOp("sb19", 1'b1, 1'b0, 3'd0, 64'd19, 64'h0000_0000_0000_00AA);
    checkOutput("sb19_value", mem[2], 64'h1122_3344_AA66_7788);
    doOp("sd24", 1'b1, 1'b0, 3'd3, 64'd24, 64'hDEAD_BEEF_CAFE_F00D);
    doOp("lw28", 1'b0, 1'b1, 3'd2, 64'd28, 64'd0);
    checkOutput("lw28_value", resp_data, 64'hFFFF_FFFF_DEAD_BEEF);
    doOp("lwu28", 1'b0, 1'b1, 3'd6, 64'd28, 64'd0);
    doOp("noop", 1'b0, 1'b0, 3'd0, 64'd40, 64'd0);
    doOp("we_re", 1'b1, 1'b1, 3'd1, 64'd44, 64'h0000_0000_0000_5A5A);

    rd0 = rd_cnt;
    doOp("lh3", 1'b0, 1'b1, 3'd1, 64'd3, 64'd0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("lh3_reads", 64'(rd_cnt - rd0), 64'd0);
`else
    checkOutput("lh3_reads", 64'(rd_cnt - rd0), 64'd1);
`endif

    $display("[TB] reset during read-modify-write");
    sh_data = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_re = 1'b0; req_funct3 = 3'd1;
    req_addr = 64'd32; req_wdata = sh_data; req_rd = 5'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
    checkOutput("rmw_rd_read", 64'(mem_read), 64'd1);
    wr0 = wr_cnt;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rmw_rst_busy", 64'(busy), 64'd0);
    checkOutput("rmw_rst_write", 64'(mem_write), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rmw_rst_no_write", 64'(wr_cnt - wr0), 64'd0);
    checkOutput("rmw_rst_mem", mem[4], refDword(4));
    checkOutput("rmw_rst_no_resp", 64'(resp_valid), 64'd0);

    $display("[TB] held request valid");
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b1; req_funct3 = 3'd3;
    req_addr = 64'd0; req_rd = 5'd3;
    @(posedge clk); #1;
    checkOutput("hold_ready_e0", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("hold_ready_e1", 64'(req_ready), 64'd0);
    checkOutput("hold_resp_e1", {63'd0, resp_valid}, 64'd1);
    checkOutput("hold_data_e1", resp_data, refDword(0));
    @(posedge clk); #1;
    checkOutput("hold_ready_e2", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    checkOutput("hold_ready_e3", 64'(req_ready), 64'd0);
    req_valid = 1'b0; req_re = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold_resp_e4", 64'(resp_valid), 64'd1);

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  kind;
      logic [2:0]  f3;
      logic [63:0] addr;
      kind = 2'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, 127));
      case (kind)
        2'd0: begin
          f3 = 3'($urandom_range(0, 7));
          doOp("rnd_store", 1'b1, 1'b0, f3, addr, {$urandom, $urandom});
        end
        2'd1, 2'd2: begin
          f3 = 3'($urandom_range(0, 6));
          doOp("rnd_load", 1'b0, 1'b1, f3, addr, 64'd0);
        end
        default: begin
          f3 = 3'($urandom_range(0, 7));
          doOp("rnd_noop", 1'b0, 1'b0, f3, addr, 64'd0);
        end
      endcase
    end

    checkOutput("rd_wr_overlap", 64'(both_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
